// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serial_subtractor_if : start/busy/done handshake and operand bundle   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface serial_subtractor_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, x, y,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, x, y,
    output busy, done, d, bout
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serial_subtractor : bit-serial d = x - y, LSB first, one bit per clk  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  sub_if
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [0:0]      S_IDLE   = 1'b0;
  localparam logic [0:0]      S_RUN    = 1'b1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, r_sr_q, r_sr_d, d_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, br_d, bout_q, done_q;
  logic             a_bit, b_bit, accept, last_step;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sub_if.start)       state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST_BIT)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: every output comes straight from a flop
  always_comb begin
    sub_if.busy = (state_q == S_RUN);
    sub_if.done = done_q;
    sub_if.d    = d_q;
    sub_if.bout = bout_q;
  end

  // Full-subtractor cell
  always_comb begin
    a_bit     = a_sr_q[0];
    b_bit     = b_sr_q[0];
    r_sr_d    = {a_bit ^ b_bit ^ br_q, r_sr_q[WIDTH-1:1]};
    br_d      = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    accept    = (state_q == S_IDLE) && sub_if.start;
    last_step = (state_q == S_RUN) && (cnt_q == LAST_BIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
      r_sr_q <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_step;
      if (accept) begin
        a_sr_q <= sub_if.x;
        b_sr_q <= sub_if.y;
        br_q   <= 1'b0;
        cnt_q  <= '0;
      end else if (state_q == S_RUN) begin
        a_sr_q <= a_sr_q >> 1;
        b_sr_q <= b_sr_q >> 1;
        r_sr_q <= r_sr_d;
        br_q   <= br_d;
        cnt_q  <= cnt_q + 1'b1;
        if (last_step) begin
          d_q    <= r_sr_d;
          bout_q <= br_d;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_serial_subtractor : directed and exhaustive checks, WIDTH = 6      |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_serial_subtractor;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  serial_subtractor_if #(.WIDTH(6)) sub_if ();

  serial_subtractor #(.WIDTH(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .sub_if (sub_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one edge, then waits (bounded) for done.
  task automatic do_op(input logic [5:0] xv, input logic [5:0] yv,
                       output logic [5:0] od, output logic ob,
                       output int lat, output int busy_cnt);
    sub_if.start = 1'b1;
    sub_if.x     = xv;
    sub_if.y     = yv;
    tick();
    sub_if.start = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!sub_if.done && lat < 20) begin
      if (sub_if.busy) busy_cnt++;
      tick();
      lat++;
    end
    od = sub_if.d;
    ob = sub_if.bout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sub_if.start = 1'b0;
    sub_if.x = '0;
    sub_if.y = '0;
    tick();
    tick();
    n_cmp++; if (sub_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", sub_if.busy); end
    n_cmp++; if (sub_if.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", sub_if.done); end
    n_cmp++; if (sub_if.d !== 6'd0) begin n_err++; $display("FAIL reset_d got %0d want 0", sub_if.d); end
    n_cmp++; if (sub_if.bout !== 1'b0) begin n_err++; $display("FAIL reset_bout got %b want 0", sub_if.bout); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [5:0] od; logic ob; int lat, bc;
    do_op(6'd10, 6'd3, od, ob, lat, bc);
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL basic_latency got %0d want 6", lat); end
    n_cmp++; if (bc !== 6) begin n_err++; $display("FAIL basic_busy_cycles got %0d want 6", bc); end
    n_cmp++; if (od !== 6'd7) begin n_err++; $display("FAIL basic_d got %0d want 7", od); end
    n_cmp++; if (ob !== 1'b0) begin n_err++; $display("FAIL basic_bout got %b want 0", ob); end
    n_cmp++; if (sub_if.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_at_done got %b want 0", sub_if.busy); end
    tick();
    n_cmp++; if (sub_if.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b want 0", sub_if.done); end
    n_cmp++; if (sub_if.d !== 6'd7) begin n_err++; $display("FAIL basic_d_hold got %0d want 7", sub_if.d); end
  endtask

  task automatic test_underflow();
    logic [5:0] xs [3] = '{6'd3, 6'd0, 6'd63};
    logic [5:0] ys [3] = '{6'd10, 6'd1, 6'd63};
    logic [5:0] ed [3] = '{6'd57, 6'd63, 6'd0};
    logic       eb [3] = '{1'b1, 1'b1, 1'b0};
    logic [5:0] od; logic ob; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      do_op(xs[i], ys[i], od, ob, lat, bc);
      n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL underflow%0d_latency got %0d want 6", i, lat); end
      n_cmp++; if (od !== ed[i]) begin n_err++; $display("FAIL underflow%0d_d got %0d want %0d", i, od, ed[i]); end
      n_cmp++; if (ob !== eb[i]) begin n_err++; $display("FAIL underflow%0d_bout got %b want %b", i, ob, eb[i]); end
      tick();
    end
  endtask

  task automatic test_busy_protect();
    int n_done = 0;
    int first_at = -1;
    logic [5:0] od = '0;
    logic ob = 1'b0;
    sub_if.start = 1'b1; sub_if.x = 6'd20; sub_if.y = 6'd5;
    tick();
    sub_if.start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 3) begin sub_if.start = 1'b1; sub_if.x = 6'd1; sub_if.y = 6'd2; end
      else if (c == 4) sub_if.start = 1'b0;
      if (sub_if.done) begin
        n_done++;
        if (first_at < 0) begin first_at = c; od = sub_if.d; ob = sub_if.bout; end
      end
    end
    n_cmp++; if (n_done !== 1) begin n_err++; $display("FAIL busy_done_count got %0d want 1", n_done); end
    n_cmp++; if (first_at !== 6) begin n_err++; $display("FAIL busy_latency got %0d want 6", first_at); end
    n_cmp++; if (od !== 6'd15) begin n_err++; $display("FAIL busy_d got %0d want 15", od); end
    n_cmp++; if (ob !== 1'b0) begin n_err++; $display("FAIL busy_bout got %b want 0", ob); end
  endtask

  task automatic test_reset_midop();
    int n_done = 0;
    sub_if.start = 1'b1; sub_if.x = 6'd40; sub_if.y = 6'd1;
    tick();
    sub_if.start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (sub_if.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", sub_if.busy); end
    n_cmp++; if (sub_if.d !== 6'd0) begin n_err++; $display("FAIL midrst_d got %0d want 0", sub_if.d); end
    n_cmp++; if (sub_if.bout !== 1'b0) begin n_err++; $display("FAIL midrst_bout got %b want 0", sub_if.bout); end
    for (int c = 0; c < 10; c++) begin
      if (sub_if.done) n_done++;
      tick();
    end
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL midrst_no_done got %0d want 0", n_done); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int n_done = 0;
    sub_if.start = 1'b1; sub_if.x = 6'd50; sub_if.y = 6'd8;
    tick();
    lat = 0;
    while (!sub_if.done && lat < 20) begin tick(); lat++; end
    n_cmp++; if (sub_if.d !== 6'd42 || sub_if.bout !== 1'b0)
      begin n_err++; $display("FAIL b2b_first got d=%0d b=%b want d=42 b=0", sub_if.d, sub_if.bout); end
    sub_if.x = 6'd7; sub_if.y = 6'd9;
    tick();
    sub_if.start = 1'b0;
    lat = 1;
    while (!sub_if.done && lat < 20) begin tick(); lat++; end
    n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL b2b_spacing got %0d want 7", lat); end
    n_cmp++; if (sub_if.d !== 6'd62 || sub_if.bout !== 1'b1)
      begin n_err++; $display("FAIL b2b_second got d=%0d b=%b want d=62 b=1", sub_if.d, sub_if.bout); end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (sub_if.done) n_done++;
    end
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL b2b_extra_done got %0d want 0", n_done); end
  endtask

  task automatic test_exhaustive();
    logic [5:0] xv, yv, ed;
    logic       eb;
    int         lat;
    sub_if.start = 1'b1; sub_if.x = 6'd0; sub_if.y = 6'd0;
    tick();
    for (int i = 0; i < 4096; i++) begin
      xv = 6'(i >> 6);
      yv = 6'(i);
      ed = xv - yv;
      eb = (xv < yv);
      lat = 0;
      while (!sub_if.done && lat < 20) begin tick(); lat++; end
      n_cmp++; if (sub_if.done !== 1'b1) begin
        n_err++; $display("FAIL exh_timeout x=%0d y=%0d got done=%b want 1", xv, yv, sub_if.done);
        sub_if.start = 1'b0;
        break;
      end
      n_cmp++; if (sub_if.d !== ed || sub_if.bout !== eb) begin
        n_err++; $display("FAIL exh x=%0d y=%0d got d=%0d b=%b want d=%0d b=%b", xv, yv, sub_if.d, sub_if.bout, ed, eb);
      end
      if (i == 4095) sub_if.start = 1'b0;
      else begin sub_if.x = 6'((i + 1) >> 6); sub_if.y = 6'(i + 1); end
      tick();
    end
    sub_if.start = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    sub_if.start = 1'b0;
    sub_if.x = '0;
    sub_if.y = '0;
    test_reset();
    test_basic();
    test_underflow();
    test_busy_protect();
    test_reset_midop();
    test_back_to_back();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
